// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares one single-port DataMemory between two requesters:
//     port 0 : integer load/store path
//     port 1 : FPU lwc1/swc1 path
//   Round-robin arbitration, a three-state sequencer (IDLE/ACCESS/RESP) and
//   per-port captured read data. DataMemory address/data_in/memRead are driven
//   from registers, so they never glitch.
//
// Handshake (both ports): a requester raises pN_req with we/addr/wdata and
//   holds all of them until it sees pN_gnt. pN_gnt is a one-cycle pulse that
//   means "fields latched". pN_done is a one-cycle pulse that means "access
//   finished". pN_err qualifies pN_done, and pN_rdata holds the last read.
//   Requests are sampled only while the sequencer is IDLE.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   pN_req/we/addr/wdata    request fields, N = 0,1
//   pN_gnt/done/err/rdata   per-port response
//   mem_addr/wdata/read     to DataMemory (mem_read=1 read, 0 write)
//   mem_rdata               from DataMemory (combinational read)
//   busy                    sequencer not IDLE
//   dbg_state               current sequencer state (debug visibility)
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 32,
  parameter int WR_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  localparam logic [3:0] WR_LAST = 4'(WR_CYCLES - 1);

  state_e              state_q;
  logic                we_q;
  logic                id_q;
  logic                last_q;      // port granted most recently
  logic [3:0]          cnt_q;       // remaining write cycles minus one
  logic [1:0]          gnt_q;
  logic [1:0]          done_q;
  logic [1:0]          err_q;
  logic [DATA_W-1:0]   rdata0_q;
  logic [DATA_W-1:0]   rdata1_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                mem_read_q;

  // Winner selection and the winner's fields, used only in IDLE.
  logic                any_req_d;
  logic                win_d;
  logic                sel_we_d;
  logic [ADDR_W-1:0]   sel_addr_d;
  logic [DATA_W-1:0]   sel_wdata_d;
  logic                sel_mis_d;

  always_comb begin
    any_req_d   = p0_req | p1_req;
    // On contention the port not granted last wins; otherwise the sole requester.
    win_d       = (p0_req && p1_req) ? ~last_q : p1_req;
    sel_we_d    = win_d ? p1_we    : p0_we;
    sel_addr_d  = win_d ? p1_addr  : p0_addr;
    sel_wdata_d = win_d ? p1_wdata : p0_wdata;
    sel_mis_d   = |sel_addr_d[1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;          // so that p0 wins the first contention
      cnt_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b1;
    end else begin
      // Response strobes are single-cycle pulses by default.
      gnt_q  <= '0;
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (any_req_d) begin
            gnt_q[win_d] <= 1'b1;
            last_q       <= win_d;
            id_q         <= win_d;
            we_q         <= sel_we_d;
            if (sel_mis_d) begin
              // Misaligned: no memory access at all, answer straight away.
              done_q[win_d] <= 1'b1;
              err_q[win_d]  <= 1'b1;
              state_q       <= S_RESP;
            end else begin
              mem_addr_q  <= sel_addr_d;
              mem_wdata_q <= sel_we_d ? sel_wdata_d : '0;
              mem_read_q  <= ~sel_we_d;
              cnt_q       <= WR_LAST;
              state_q     <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (!we_q || cnt_q == 4'd0) begin
            if (!we_q) begin
              if (id_q) rdata1_q <= mem_rdata;
              else      rdata0_q <= mem_rdata;
            end
            done_q[id_q] <= 1'b1;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_read_q   <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign p0_gnt    = gnt_q[0];
  assign p1_gnt    = gnt_q[1];
  assign p0_done   = done_q[0];
  assign p1_done   = done_q[1];
  assign p0_err    = err_q[0];
  assign p1_err    = err_q[1];
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  localparam int WR_CYCLES = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        p0_req, p0_we, p1_req, p1_we;
  logic [5:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_read, busy;
  logic [1:0]  dbg_state;

  dmem_port_arbiter #(.ADDR_W(6), .DATA_W(32), .WR_CYCLES(WR_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // DataMemory stand-in: combinational read, write on clock edge while memRead=0.
  logic [31:0] dmem [16];
  assign mem_rdata = dmem[mem_addr[5:2]];
  always @(posedge clk) if (!mem_read) dmem[mem_addr[5:2]] <= mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model / scoreboard state ----------------
  logic [31:0] ref_mem [16];
  logic [31:0] exp_rdata [2];
  int          last_gnt;
  int          checks = 0;
  int          failures = 0;
  int          done_cyc = 0;
  int          prev_done_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctl_vec();
    return {24'd0, p1_gnt, p0_gnt, p1_done, p0_done, p1_err, p0_err, busy, mem_read};
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, "_ctl"}, ctl_vec(), 32'h01);
    chk({tag, "_addr"}, {26'd0, mem_addr}, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
  endtask

  // Pulse reset mid-cycle and check the asynchronous effect immediately.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_quiet(tag);
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    last_gnt = 1;
    chk({tag, "_rd0"}, p0_rdata, 32'd0);
    chk({tag, "_rd1"}, p1_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- driver + per-cycle checking ----------------
  // Presents up to two requests together, derives the grant order, latencies
  // and memory effects from the arbitration rules, then checks every cycle.
  task automatic serve(input bit v0, input bit v1, input bit w0, input bit w1,
                       input logic [5:0] a0, input logic [5:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    bit          v [2];
    bit          w [2];
    logic [5:0]  a [2];
    logic [31:0] wd [2];
    bit          mis [2];
    int          g [2];
    int          dn [2];
    int          first, t, e_end;
    v[0] = v0; v[1] = v1; w[0] = w0; w[1] = w1;
    a[0] = a0; a[1] = a1; wd[0] = d0; wd[1] = d1;
    g[0] = -10; g[1] = -10; dn[0] = -10; dn[1] = -10;
    first = (v0 && v1) ? ((last_gnt == 0) ? 1 : 0) : (v1 ? 1 : 0);
    t = 0;
    for (int k = 0; k < 2; k++) begin
      int p;
      p = (k == 0) ? first : 1 - first;
      if (v[p]) begin
        mis[p] = (a[p][1:0] != 2'b00);
        g[p]   = t;
        dn[p]  = t + (mis[p] ? 0 : (w[p] ? WR_CYCLES : 1));
        t      = dn[p] + 2;
        last_gnt = p;
      end else begin
        mis[p] = 1'b0;
      end
    end
    e_end = t - 1;

    @(negedge clk);
    p0_req = v0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = v1; p1_we = w1; p1_addr = a1; p1_wdata = d1;

    for (int e = 0; e <= e_end; e++) begin
      logic [1:0]  xg, xd, xe;
      logic        xbusy, xrd, in_acc, rd_acc;
      logic [5:0]  xaddr;
      logic [31:0] xwd;
      @(posedge clk);
      #1;
      xg = '0; xd = '0; xe = '0; xbusy = 1'b0; xrd = 1'b1;
      xaddr = '0; xwd = '0; rd_acc = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (v[p]) begin
          in_acc = !mis[p] && e >= g[p] && e < dn[p];
          if (e == g[p])  xg[p] = 1'b1;
          if (e == dn[p]) begin
            xd[p] = 1'b1;
            xe[p] = mis[p];
            if (!mis[p] && w[p])  ref_mem[a[p][5:2]] = wd[p];
            if (!mis[p] && !w[p]) exp_rdata[p] = ref_mem[a[p][5:2]];
          end
          if (e >= g[p] && e <= dn[p]) xbusy = 1'b1;
          if (in_acc) begin
            xaddr = a[p];
            if (w[p]) begin
              xrd = 1'b0;
              xwd = wd[p];
            end else begin
              rd_acc = 1'b1;
            end
          end
        end
      end
      if (p0_done || p1_done) begin
        prev_done_cyc = done_cyc;
        done_cyc = cyc;
      end
      chk($sformatf("ctl_e%0d", e), ctl_vec(), {24'd0, xg[1], xg[0], xd[1], xd[0], xe[1], xe[0], xbusy, xrd});
      chk($sformatf("mem_addr_e%0d", e), {26'd0, mem_addr}, {26'd0, xaddr});
      if (!rd_acc) chk($sformatf("mem_wdata_e%0d", e), mem_wdata, xwd);
      chk($sformatf("p0_rdata_e%0d", e), p0_rdata, exp_rdata[0]);
      chk($sformatf("p1_rdata_e%0d", e), p1_rdata, exp_rdata[1]);
      if (e == g[0]) p0_req = 1'b0;
      if (e == g[1]) p1_req = 1'b0;
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    for (int i = 0; i < 16; i++) begin
      dmem[i] = '0;
      ref_mem[i] = '0;
    end
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    last_gnt = 1;

    // Reset asserted mid-clock.
    #3 rst_n = 1'b0;
    #1 check_quiet("reset_async");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Write then read back on p0.
    serve(1, 0, 1, 0, 6'd0, 6'd0, 32'h12345678, 32'd0);
    serve(1, 0, 0, 0, 6'd0, 6'd0, 32'd0, 32'd0);

    // Two more writes, then back-to-back reads at one done per three cycles.
    serve(1, 0, 1, 0, 6'd4, 6'd0, 32'h56565656, 32'd0);
    serve(1, 0, 1, 0, 6'd8, 6'd0, 32'hb8989898, 32'd0);
    serve(1, 0, 0, 0, 6'd0, 6'd0, 32'd0, 32'd0);
    serve(1, 0, 0, 0, 6'd4, 6'd0, 32'd0, 32'd0);
    chk("read_spacing_a", done_cyc - prev_done_cyc, 32'd3);
    serve(1, 0, 0, 0, 6'd8, 6'd0, 32'd0, 32'd0);
    chk("read_spacing_b", done_cyc - prev_done_cyc, 32'd3);

    // Contention after reset: p0 first; after a lone p0 grant, p1 wins.
    do_reset("reset_mid");
    serve(1, 1, 0, 0, 6'd0, 6'd4, 32'd0, 32'd0);
    serve(1, 0, 0, 0, 6'd8, 6'd0, 32'd0, 32'd0);
    serve(1, 1, 0, 0, 6'd4, 6'd8, 32'd0, 32'd0);
    serve(1, 1, 1, 0, 6'd12, 6'd12, 32'hcafef00d, 32'd0);

    // Misaligned p1 read: error, no memory activity.
    serve(0, 1, 0, 0, 6'd0, 6'd6, 32'd0, 32'd0);
    serve(0, 1, 1, 0, 6'd0, 6'd9, 32'd0, 32'hffffffff);

    // Reset in the middle of a write to address 4.
    @(negedge clk);
    p0_req = 1; p0_we = 1; p0_addr = 6'd4; p0_wdata = 32'hdeadbeef;
    @(posedge clk);
    #1 chk("abort_gnt_ctl", ctl_vec(), 32'h42);
    p0_req = 0;
    #2 rst_n = 1'b0;
    #1 check_quiet("abort_reset");
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    last_gnt = 1;
    @(posedge clk);
    #1 chk("abort_no_done", ctl_vec(), 32'h01);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk("abort_idle", ctl_vec(), 32'h01);
    serve(1, 0, 0, 0, 6'd4, 6'd0, 32'd0, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 30; i++) begin
      bit v0, v1;
      logic [5:0] a0, a1;
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      a0 = 6'($urandom_range(0, 15) << 2);
      a1 = 6'($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 7) == 0) a0[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) a1[1:0] = 2'($urandom_range(1, 3));
      serve(v0, v1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            a0, a1, $urandom, $urandom);
    end

    // Memory contents must match the model (no spurious or lost writes).
    for (int i = 0; i < 16; i++) chk($sformatf("mem_word%0d", i), dmem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
